// File: rtl/trigger_capture_ctrl_pkg.sv
// Shared definitions for the trigger capture controller:
// state encodings, trigger source bit indices and default widths.
package trigger_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POST  = 2'd1,
        ST_READY = 2'd2,
        ST_DEAD  = 2'd3
    } cap_state_t;

    localparam int SRC_SB   = 0;
    localparam int SRC_TOT  = 1;
    localparam int SRC_TOTD = 2;
    localparam int SRC_MOPS = 3;
    localparam int SRC_EXT  = 4;

    localparam int DEF_NSRC       = 5;
    localparam int DEF_TS_WIDTH   = 32;
    localparam int DEF_POST_WIDTH = 12;
    localparam int DEF_HOLD_WIDTH = 8;
    localparam int DEF_MISS_WIDTH = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trigger_capture_ctrl_tick_down_counter.sv
// Loadable down counter that only moves on 40 MHz ticks;
// last flags the tick on which the count reaches its end.
module trigger_capture_ctrl_tick_down_counter
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int W = DEF_POST_WIDTH
) (
    input  logic         CLK120,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK120) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = tick && (cnt == W'(1));

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Trigger consumer: accepts masked 40 MHz trigger pulses, runs the
// post-trigger window, freezes capture and hands the event to readout.
module trigger_capture_ctrl
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int NSRC       = DEF_NSRC,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int POST_WIDTH = DEF_POST_WIDTH,
    parameter int HOLD_WIDTH = DEF_HOLD_WIDTH,
    parameter int MISS_WIDTH = DEF_MISS_WIDTH
) (
    input  logic                  CLK120,
    input  logic                  RST,
    input  logic [1:0]            ENABLE40,
    input  logic [NSRC-1:0]       TRIG_IN,
    input  logic [NSRC-1:0]       TRIG_MASK,
    input  logic [POST_WIDTH-1:0] POST_LEN,
    input  logic [HOLD_WIDTH-1:0] HOLDOFF,
    input  logic                  EVT_ACK,
    output logic                  CAPTURE_EN,
    output logic                  EVT_READY,
    output logic [NSRC-1:0]       EVT_SRC,
    output logic [TS_WIDTH-1:0]   EVT_TIME,
    output logic [MISS_WIDTH-1:0] MISSED,
    output logic                  BUSY
);

    localparam int CNT_W = max_int(POST_WIDTH, HOLD_WIDTH);

    cap_state_t state;
    cap_state_t state_nx;

    logic [1:0]          lcl_enable40;
    logic [TS_WIDTH-1:0] ts;
    logic [NSRC-1:0]     src_m;
    logic                tick;
    logic                hit;
    logic                miss;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_tick;
    logic                cnt_last;

    logic                accept;
    logic                capture_nx;
    logic                ready_nx;
    logic                busy_nx;

    assign src_m    = TRIG_IN & TRIG_MASK;
    assign tick     = (lcl_enable40 == 2'b00);
    assign hit      = tick && (|src_m);
    assign miss     = hit && (state != ST_IDLE) && !(&MISSED);
    assign cnt_tick = tick && ((state == ST_POST) || (state == ST_DEAD));

    // Phase register resets to 3 so the first post-reset cycle is never a tick
    always_ff @(posedge CLK120) begin
        if (RST) begin
            lcl_enable40 <= 2'b11;
            ts           <= '0;
        end else begin
            lcl_enable40 <= ENABLE40;
            if (tick) begin
                ts <= ts + 1'b1;
            end
        end
    end

    trigger_capture_ctrl_tick_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .CLK120   (CLK120),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (cnt_tick),
        .last     (cnt_last)
    );

    always_ff @(posedge CLK120) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(POST_LEN);
                    state_nx = (POST_LEN == '0) ? ST_READY : ST_POST;
                end
            end
            ST_POST: begin
                if (cnt_last) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                if (EVT_ACK) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(HOLDOFF);
                    state_nx = (HOLDOFF == '0) ? ST_IDLE : ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (cnt_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        capture_nx = (state_nx == ST_IDLE) || (state_nx == ST_POST);
        ready_nx   = (state_nx == ST_READY);
        busy_nx    = (state_nx != ST_IDLE);
    end

    // Flags are registered from the next state so they line up with it
    always_ff @(posedge CLK120) begin
        if (RST) begin
            CAPTURE_EN <= 1'b0;
            EVT_READY  <= 1'b0;
            BUSY       <= 1'b0;
            EVT_SRC    <= '0;
            EVT_TIME   <= '0;
            MISSED     <= '0;
        end else begin
            CAPTURE_EN <= capture_nx;
            EVT_READY  <= ready_nx;
            BUSY       <= busy_nx;
            if (accept) begin
                EVT_SRC  <= src_m;
                EVT_TIME <= ts;
            end
            if (miss) begin
                MISSED <= MISSED + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Scoreboard bench for trigger_capture_ctrl; a second instance with a
// 2-bit miss counter exercises saturation.
module tb_trigger_capture_ctrl;

    logic        CLK120 = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  en40 = 2'd0;
    logic [4:0]  trig = '0;
    logic [4:0]  mask = 5'h1f;
    logic [11:0] post_len = 12'd4;
    logic [7:0]  holdoff = 8'd0;
    logic        ack = 1'b0;

    logic        cap, rdy, busy;
    logic [4:0]  src;
    logic [31:0] etime;
    logic [15:0] missed;

    logic        cap_s, rdy_s, busy_s;
    logic [4:0]  src_s;
    logic [31:0] etime_s;
    logic [1:0]  missed_s;

    int total = 0;
    int bad = 0;

    logic [31:0] m_ts = '0;
    logic [1:0]  m_lcl = 2'b11;

    typedef struct packed {
        logic [4:0]  src;
        logic [31:0] t;
    } evt_t;

    evt_t sb_q[$];

    trigger_capture_ctrl dut (
        .CLK120     (CLK120),
        .RST        (RST),
        .ENABLE40   (en40),
        .TRIG_IN    (trig),
        .TRIG_MASK  (mask),
        .POST_LEN   (post_len),
        .HOLDOFF    (holdoff),
        .EVT_ACK    (ack),
        .CAPTURE_EN (cap),
        .EVT_READY  (rdy),
        .EVT_SRC    (src),
        .EVT_TIME   (etime),
        .MISSED     (missed),
        .BUSY       (busy)
    );

    trigger_capture_ctrl #(
        .MISS_WIDTH (2)
    ) dut_s (
        .CLK120     (CLK120),
        .RST        (RST),
        .ENABLE40   (en40),
        .TRIG_IN    (trig),
        .TRIG_MASK  (mask),
        .POST_LEN   (post_len),
        .HOLDOFF    (holdoff),
        .EVT_ACK    (ack),
        .CAPTURE_EN (cap_s),
        .EVT_READY  (rdy_s),
        .EVT_SRC    (src_s),
        .EVT_TIME   (etime_s),
        .MISSED     (missed_s),
        .BUSY       (busy_s)
    );

    always #4 CLK120 = ~CLK120;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // One clock: update the tick/timestamp model, then move the phase input
    task automatic step();
        @(posedge CLK120);
        if (RST) begin
            m_lcl = 2'b11;
            m_ts  = '0;
        end else begin
            if (m_lcl == 2'b00) m_ts = m_ts + 1;
            m_lcl = en40;
        end
        #1;
        en40 = (en40 == 2'd2) ? 2'd0 : en40 + 2'd1;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 4 && m_lcl != 2'b00; i++) step();
    endtask

    task automatic push_evt(input logic [4:0] s);
        evt_t e;
        e.src = s;
        e.t   = m_ts;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        trig = '0;
        ack = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        mask = 5'h1f;
        RST = 1'b1;
        repeat (3) step();
        total++; if (cap !== 1'b0) begin bad++; $display("FAIL rst_cap: got %0h exp 0", cap); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %0h exp 0", rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h exp 0", busy); end
        total++; if (missed !== 16'h0) begin bad++; $display("FAIL rst_missed: got %0h exp 0", missed); end
        total++; if (src !== 5'h0) begin bad++; $display("FAIL rst_src: got %0h exp 0", src); end
        total++; if (etime !== 32'h0) begin bad++; $display("FAIL rst_time: got %0h exp 0", etime); end
        RST = 1'b0;
        trig = 5'h1f;
        step();
        trig = '0;
        total++; if (cap !== 1'b1) begin bad++; $display("FAIL rel_cap: got %0h exp 1", cap); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_no_tick: got %0h exp 0", busy); end
        total++; if (missed !== 16'h0) begin bad++; $display("FAIL rel_missed: got %0h exp 0", missed); end
    endtask

    task automatic test_single();
        evt_t e;
        int n;
        bit early;
        do_reset();
        mask = 5'h1f;
        post_len = 12'd4;
        holdoff = 8'd0;
        for (int i = 0; i < 1000 && !(m_lcl == 2'b00 && m_ts == 32'd100); i++) step();
        trig = 5'b00001;
        push_evt(5'b00001);
        step();
        trig = '0;
        post_len = 12'd9;
        n = 0;
        early = 1'b0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            bit was;
            was = (m_lcl == 2'b00);
            step();
            if (was) n++;
            if (n < 4 && (rdy !== 1'b0 || cap !== 1'b1)) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL post_early: got rdy %0h exp 0 before 4 ticks", rdy); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL post_rdy: got %0h exp 1", rdy); end
        total++; if (cap !== 1'b0) begin bad++; $display("FAIL post_cap: got %0h exp 0", cap); end
        e = sb_q.pop_front();
        total++; if (src !== e.src) begin bad++; $display("FAIL single_src: got %0h exp %0h", src, e.src); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL single_time: got %0d exp %0d", etime, e.t); end
        total++; if (etime !== 32'd100) begin bad++; $display("FAIL single_t100: got %0d exp 100", etime); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL single_ack: got %0h exp 0", rdy); end
    endtask

    task automatic test_mask();
        evt_t e;
        do_reset();
        post_len = 12'd1;
        holdoff = 8'd0;
        mask = 5'b00100;
        wait_tick();
        trig = 5'b00101;
        push_evt(5'b00100);
        step();
        trig = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mask_accept: got %0h exp 1", busy); end
        for (int i = 0; i < 50 && rdy !== 1'b1; i++) step();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL mask_ready: got %0h exp 1", rdy); end
        e = sb_q.pop_front();
        total++; if (src !== e.src) begin bad++; $display("FAIL mask_src: got %0h exp %0h", src, e.src); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL mask_time: got %0d exp %0d", etime, e.t); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_idle: got %0h exp 0", busy); end
        mask = 5'b11101;
        wait_tick();
        trig = 5'b00010;
        step();
        trig = '0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL masked_busy: got %0h exp 0", busy); end
        total++; if (missed !== 16'h0) begin bad++; $display("FAIL masked_missed: got %0h exp 0", missed); end
        total++; if (src !== 5'b00100) begin bad++; $display("FAIL masked_src_hold: got %0h exp 4", src); end
    endtask

    task automatic test_missed();
        evt_t e;
        do_reset();
        mask = 5'h1f;
        post_len = 12'd2;
        holdoff = 8'd2;
        wait_tick();
        trig = 5'b00001;
        push_evt(5'b00001);
        step();
        trig = '0;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            trig = 5'b01000;
            step();
            trig = '0;
        end
        total++; if (missed !== 16'd3) begin bad++; $display("FAIL miss3: got %0d exp 3", missed); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL miss_rdy: got %0h exp 1", rdy); end
        e = sb_q.pop_front();
        total++; if (src !== e.src) begin bad++; $display("FAIL miss_src: got %0h exp %0h", src, e.src); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL miss_time: got %0d exp %0d", etime, e.t); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        holdoff = 8'd7;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL dead_rdy: got %0h exp 0", rdy); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dead_busy: got %0h exp 1", busy); end
        total++; if (cap !== 1'b0) begin bad++; $display("FAIL dead_cap: got %0h exp 0", cap); end
        wait_tick();
        trig = 5'b10000;
        step();
        trig = '0;
        total++; if (missed !== 16'd4) begin bad++; $display("FAIL miss4: got %0d exp 4", missed); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dead_tick1: got %0h exp 1", busy); end
        wait_tick();
        trig = 5'b00001;
        step();
        trig = '0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dead_exit: got %0h exp 0", busy); end
        total++; if (missed !== 16'd5) begin bad++; $display("FAIL exit_hit_missed: got %0d exp 5", missed); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL exit_hit_time: got %0d exp %0d", etime, e.t); end
        total++; if (cap !== 1'b1) begin bad++; $display("FAIL exit_cap: got %0h exp 1", cap); end
    endtask

    task automatic test_zero_len();
        evt_t e;
        do_reset();
        mask = 5'h1f;
        post_len = 12'd0;
        holdoff = 8'd0;
        wait_tick();
        trig = 5'b00010;
        push_evt(5'b00010);
        step();
        trig = '0;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL zero_rdy: got %0h exp 1", rdy); end
        total++; if (cap !== 1'b0) begin bad++; $display("FAIL zero_cap: got %0h exp 0", cap); end
        e = sb_q.pop_front();
        total++; if (src !== e.src) begin bad++; $display("FAIL zero_src: got %0h exp %0h", src, e.src); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL zero_time: got %0d exp %0d", etime, e.t); end
        for (int i = 0; i < 4 && m_lcl != 2'd2; i++) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_ack_idle: got %0h exp 0", busy); end
        trig = 5'b00100;
        push_evt(5'b00100);
        step();
        trig = '0;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL idle_entry_accept: got %0h exp 1", rdy); end
        e = sb_q.pop_front();
        total++; if (src !== e.src) begin bad++; $display("FAIL entry_src: got %0h exp %0h", src, e.src); end
        total++; if (etime !== e.t) begin bad++; $display("FAIL entry_time: got %0d exp %0d", etime, e.t); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL zero_ack2: got %0h exp 0", rdy); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_ack_busy: got %0h exp 0", busy); end
        total++; if (cap !== 1'b1) begin bad++; $display("FAIL idle_ack_cap: got %0h exp 1", cap); end
        total++; if (missed !== 16'h0) begin bad++; $display("FAIL zero_missed: got %0d exp 0", missed); end
    endtask

    task automatic test_saturate_reset();
        evt_t e;
        do_reset();
        mask = 5'h1f;
        post_len = 12'd1;
        holdoff = 8'd0;
        wait_tick();
        trig = 5'b00001;
        push_evt(5'b00001);
        step();
        trig = '0;
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            trig = 5'b00010;
            step();
            trig = '0;
        end
        total++; if (missed_s !== 2'd2) begin bad++; $display("FAIL sat_near: got %0d exp 2", missed_s); end
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            trig = 5'b00010;
            step();
            trig = '0;
        end
        total++; if (missed_s !== 2'd3) begin bad++; $display("FAIL sat_full: got %0d exp 3", missed_s); end
        total++; if (missed !== 16'd5) begin bad++; $display("FAIL sat_wide: got %0d exp 5", missed); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL sat_rdy: got %0h exp 1", rdy); end
        e = sb_q.pop_front();
        total++; if (etime !== e.t) begin bad++; $display("FAIL sat_time: got %0d exp %0d", etime, e.t); end
        RST = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrdy_busy: got %0h exp 0", busy); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rstrdy_rdy: got %0h exp 0", rdy); end
        total++; if (missed !== 16'h0) begin bad++; $display("FAIL rstrdy_missed: got %0d exp 0", missed); end
        total++; if (missed_s !== 2'd0) begin bad++; $display("FAIL rstrdy_missed_s: got %0d exp 0", missed_s); end
        RST = 1'b0;
        step();
        total++; if (cap !== 1'b1) begin bad++; $display("FAIL rstrdy_cap: got %0h exp 1", cap); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrdy_idle: got %0h exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask();
        test_missed();
        test_zero_len();
        test_saturate_reset();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d exp 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_capture_ctrl.md
Name: trigger_capture_ctrl

Overview:
Consumer end of the 40 MHz trigger pulses produced by the single-bin, ToT, ToTd and MoPS trigger blocks.
- Accepts one-tick TRIG pulses from up to NSRC sources and applies an enable mask.
- On the first accepted trigger: latches source bits and a 40 MHz timestamp, runs a post-trigger sample window, freezes trace capture, then signals the readout path.
- Waits for a readout acknowledge, enforces a hold-off, and counts triggers lost while not idle.

Parameters:
NSRC, 5, number of trigger sources (bit 0 = SB, 1 = ToT, 2 = ToTd, 3 = MoPS, 4 = external)
TS_WIDTH, 32, timestamp counter width (40 MHz ticks)
POST_WIDTH, 12, width of post-trigger length
HOLD_WIDTH, 8, width of hold-off length
MISS_WIDTH, 16, width of missed-trigger counter

Ports:
CLK120  in  1  120 MHz clock; sole clock domain
RST  in  1  synchronous, active-high reset
ENABLE40  in  2  40 MHz phase from the common phase generator
TRIG_IN  in  NSRC  one-tick trigger pulses, valid on the tick
TRIG_MASK  in  NSRC  1 = source enabled
POST_LEN  in  POST_WIDTH  post-trigger ticks before freeze
HOLDOFF  in  HOLD_WIDTH  dead ticks after acknowledge
EVT_ACK  in  1  readout done; one-cycle pulse, any phase
CAPTURE_EN  out  1  trace buffer write enable
EVT_READY  out  1  event frozen and awaiting readout
EVT_SRC  out  NSRC  masked sources present on the trigger tick
EVT_TIME  out  TS_WIDTH  timestamp of the trigger tick
MISSED  out  MISS_WIDTH  saturating count of lost triggers
BUSY  out  1  state is not IDLE

Behaviour:
- Clocking and reset:
  - Single clock CLK120. RST is synchronous and active-high.
  - All outputs are registered.
  - Reset values: every output 0; state IDLE; TS 0; LCL_ENABLE40 = 2'b11, so no spurious tick occurs after reset.
  - CAPTURE_EN rises on the first cycle after RST deasserts.
- Tick:
  - LCL_ENABLE40 <= ENABLE40 every cycle.
  - tick = (LCL_ENABLE40 == 0), i.e. one cycle per three.
  - TS increments on every tick and wraps modulo 2^TS_WIDTH.
- hit = tick && |(TRIG_IN & TRIG_MASK). The mask is sampled live, never latched.
- States:
  - IDLE: CAPTURE_EN=1, EVT_READY=0. On hit:
    - latch EVT_SRC = TRIG_IN & TRIG_MASK and EVT_TIME = TS (pre-increment value);
    - load CNT = POST_LEN;
    - go to POST, or directly to READY if POST_LEN == 0.
  - POST: CAPTURE_EN=1. On each tick, CNT decrements. On the tick where CNT == 1, go to READY.
    - Net result: exactly POST_LEN ticks after the trigger tick.
  - READY: CAPTURE_EN=0, EVT_READY=1. On EVT_ACK in any cycle:
    - load CNT = HOLDOFF and go to DEAD;
    - go directly to IDLE if HOLDOFF == 0.
    - EVT_READY drops the cycle after the acknowledge.
  - DEAD: CAPTURE_EN=0. On each tick, CNT decrements. At CNT == 1 on a tick, go to IDLE.
    - Net result: exactly HOLDOFF ticks.
- Latching and counters:
  - EVT_SRC and EVT_TIME hold their values until the next accepted trigger.
  - MISSED increments by 1 for each hit in POST, READY or DEAD, at most once per tick. It saturates at all-ones and is cleared only by RST.
  - A hit on the same tick as the DEAD→IDLE transition counts as missed, not accepted.
  - A hit in IDLE on the tick it is entered is accepted.
- Ignored and sampled inputs:
  - EVT_ACK outside READY is ignored.
  - POST_LEN is sampled only on the accepting tick.
  - HOLDOFF is sampled only on the acknowledge cycle.
- RST in any state returns to IDLE within one cycle. MISSED clears and any pending event is discarded.

Decomposition:
- Add to sde_trigger_defs.vh:
  - state encodings (IDLE=0, POST=1, READY=2, DEAD=3);
  - source bit indices;
  - default widths.
- One natural sub-module: tick_down_counter. It is a loadable, tick-gated down counter with a "last" flag, instantiated once; CNT is shared by POST and DEAD with width max(POST_WIDTH, HOLD_WIDTH).

Test Plan:
1. Reset release, MASK=5'b11111, no triggers → CAPTURE_EN=1 the cycle after RST falls; TS increments every third cycle; no tick occurs in the first post-reset cycle.
2. TRIG_IN=5'b00001 on a tick with TS=100, POST_LEN=4 → EVT_SRC=00001, EVT_TIME=100; EVT_READY=1 and CAPTURE_EN=0 take effect exactly 4 ticks later.
3. TRIG_IN=5'b00101 with MASK=5'b00100, then TRIG_IN=5'b00010 with MASK=5'b11101 → first is accepted with EVT_SRC=00100; second is fully masked, causes no state change, and MISSED stays 0.
4. Trigger accepted, then 3 hits during POST/READY, then EVT_ACK with HOLDOFF=2, then a hit 1 tick later → MISSED=4; IDLE is reached 2 ticks after the acknowledge.
5. POST_LEN=0 and HOLDOFF=0 → READY on the cycle after the trigger tick; IDLE on the cycle after EVT_ACK; an EVT_ACK pulse in IDLE is ignored.
6. MISSED preloaded near saturation (16'hFFFE) plus 3 missed hits → MISSED=16'hFFFF. Then assert RST while in READY → IDLE, EVT_READY=0, MISSED=0.
